// File: rtl/nn_pkg.sv
// Shared types and sizes for the neural-network decision path.
// N_CLASSES tracks the final dense layer's output width.
package nn_pkg;
    localparam int FINAL_LAYER_OUT = 4;
    localparam int N_CLASSES       = FINAL_LAYER_OUT;
    localparam int PROB_W          = 16;
    localparam int CLASS_W         = $clog2(N_CLASSES);

    typedef logic [PROB_W-1:0] prob_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        DECIDE = 2'd2
    } dec_state_t;
endpackage

// File: rtl/argmax_scan.sv
// Serial arg-max over a registered probability vector, one entry per cycle.
// Ties keep the lowest index because only a strictly greater entry replaces the max.
module argmax_scan #(
    parameter int N_CLASSES = nn_pkg::N_CLASSES,
    parameter int PROB_W    = nn_pkg::PROB_W,
    localparam int CLASS_W  = $clog2(N_CLASSES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [PROB_W-1:0] probs [0:N_CLASSES-1],
    output logic              done,
    output logic [PROB_W-1:0] max_val,
    output logic [CLASS_W-1:0] max_idx
);
    logic               r_active;
    logic [CLASS_W-1:0] r_idx;
    logic [PROB_W-1:0]  r_max_val;
    logic [CLASS_W-1:0] r_max_idx;

    logic               w_last;
    logic [PROB_W-1:0]  w_entry;

    assign w_last  = (r_idx == CLASS_W'(N_CLASSES - 1));
    assign w_entry = probs[r_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_active  <= 1'b0;
            r_idx     <= '0;
            r_max_val <= '0;
            r_max_idx <= '0;
        end else if (start) begin
            r_active <= 1'b1;
            r_idx    <= '0;
        end else if (r_active) begin
            // Entry 0 seeds the running max regardless of stale contents.
            if (r_idx == '0 || w_entry > r_max_val) begin
                r_max_val <= w_entry;
                r_max_idx <= r_idx;
            end
            if (w_last) begin
                r_active <= 1'b0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign done    = r_active && w_last;
    assign max_val = r_max_val;
    assign max_idx = r_max_idx;
endmodule

// File: rtl/class_decision_unit.sv
// Decision end of the NN path: arg-max, confidence threshold and a streak filter
// that emits one detection pulse once the same winner persists HOLD_FRAMES frames.
module class_decision_unit #(
    parameter int N_CLASSES   = nn_pkg::N_CLASSES,
    parameter int PROB_W      = nn_pkg::PROB_W,
    parameter int HOLD_FRAMES = 3,
    localparam int CLASS_W    = $clog2(N_CLASSES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    // Handshake: a frame transfers on a rising edge where prob_valid && prob_ready.
    // Upstream holds probabilities/threshold stable until that edge.
    input  logic                   prob_valid,
    output logic                   prob_ready,
    input  logic [PROB_W-1:0]      probabilities [0:N_CLASSES-1],
    input  logic [PROB_W-1:0]      threshold,
    input  logic                   clear,
    output logic                   det_valid,
    output logic [CLASS_W-1:0]     det_class,
    output logic [PROB_W-1:0]      det_conf,
    output logic                   busy,
    output nn_pkg::dec_state_t     dbg_state,
    output logic [3:0]             dbg_streak
);
    import nn_pkg::*;

    localparam logic [3:0] HOLD = 4'(HOLD_FRAMES);

    dec_state_t         r_state;
    logic [PROB_W-1:0]  r_probs [0:N_CLASSES-1];
    logic [PROB_W-1:0]  r_thresh;
    logic [3:0]         r_streak;
    logic [CLASS_W-1:0] r_last_idx;
    logic               r_last_ok;
    logic               r_det_valid;
    logic [CLASS_W-1:0] r_det_class;
    logic [PROB_W-1:0]  r_det_conf;

    logic               w_accept;
    logic               w_done;
    logic [PROB_W-1:0]  w_max_val;
    logic [CLASS_W-1:0] w_max_idx;
    logic               w_cand_ok;
    logic               w_same;
    logic [3:0]         w_streak_nxt;
    logic               w_fire;

    assign w_accept = prob_valid && (r_state == IDLE);

    argmax_scan #(
        .N_CLASSES (N_CLASSES),
        .PROB_W    (PROB_W)
    ) u_scan (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_accept),
        .probs   (r_probs),
        .done    (w_done),
        .max_val (w_max_val),
        .max_idx (w_max_idx)
    );

    assign w_cand_ok = (w_max_val >= r_thresh);
    assign w_same    = w_cand_ok && r_last_ok && (w_max_idx == r_last_idx);

    always_comb begin
        w_streak_nxt = 4'd0;
        if (w_same) begin
            w_streak_nxt = (r_streak >= HOLD) ? HOLD : r_streak + 4'd1;
        end else if (w_cand_ok) begin
            w_streak_nxt = 4'd1;
        end
    end

    // A winner already held at HOLD does not retrigger; any restarted streak that
    // reaches HOLD does.
    assign w_fire = (r_state == DECIDE) && !clear && (w_streak_nxt == HOLD)
                    && !(w_same && r_streak == HOLD);

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_probs <= probabilities;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_thresh    <= '0;
            r_streak    <= 4'd0;
            r_last_idx  <= '0;
            r_last_ok   <= 1'b0;
            r_det_valid <= 1'b0;
            r_det_class <= '0;
            r_det_conf  <= '0;
        end else begin
            r_det_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_thresh <= threshold;
                        r_state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_done) begin
                        r_state <= DECIDE;
                    end
                end
                DECIDE: begin
                    r_state    <= IDLE;
                    r_streak   <= w_streak_nxt;
                    r_last_idx <= w_max_idx;
                    r_last_ok  <= w_cand_ok;
                    if (w_fire) begin
                        r_det_valid <= 1'b1;
                        r_det_class <= w_max_idx;
                        r_det_conf  <= w_max_val;
                    end
                end
                default: r_state <= IDLE;
            endcase
            // Flush overrides the DECIDE update above.
            if (clear) begin
                r_streak  <= 4'd0;
                r_last_ok <= 1'b0;
            end
        end
    end

    assign prob_ready = (r_state == IDLE);
    assign busy       = (r_state != IDLE);
    assign det_valid  = r_det_valid;
    assign det_class  = r_det_class;
    assign det_conf   = r_det_conf;
    assign dbg_state  = r_state;
    assign dbg_streak = r_streak;
endmodule

// File: tb/tb_class_decision_unit.sv
// Bench for class_decision_unit: HOLD_FRAMES=3 and HOLD_FRAMES=1 instances share
// stimulus and are checked against a frame-level reference model.
module tb_class_decision_unit;
    import nn_pkg::*;

    localparam int N = 4;
    localparam int W = 16;
    localparam int NDUT = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       prob_valid = 1'b0;
    logic       clear = 1'b0;
    prob_t      probs [0:N-1];
    prob_t      threshold = 16'h4000;

    logic       rdy  [NDUT];
    logic       bsy  [NDUT];
    logic       dv   [NDUT];
    logic [1:0] dcls [NDUT];
    prob_t      dconf[NDUT];
    dec_state_t st   [NDUT];
    logic [3:0] stk  [NDUT];

    class_decision_unit #(.N_CLASSES(N), .PROB_W(W), .HOLD_FRAMES(3)) u_h3 (
        .clk(clk), .rst_n(rst_n), .prob_valid(prob_valid), .prob_ready(rdy[0]),
        .probabilities(probs), .threshold(threshold), .clear(clear),
        .det_valid(dv[0]), .det_class(dcls[0]), .det_conf(dconf[0]), .busy(bsy[0]),
        .dbg_state(st[0]), .dbg_streak(stk[0])
    );

    class_decision_unit #(.N_CLASSES(N), .PROB_W(W), .HOLD_FRAMES(1)) u_h1 (
        .clk(clk), .rst_n(rst_n), .prob_valid(prob_valid), .prob_ready(rdy[1]),
        .probabilities(probs), .threshold(threshold), .clear(clear),
        .det_valid(dv[1]), .det_class(dcls[1]), .det_conf(dconf[1]), .busy(bsy[1]),
        .dbg_state(st[1]), .dbg_streak(stk[1])
    );

    // ---------------- scoreboard / model ----------------
    int n_checks = 0;
    int n_errs = 0;

    logic [W+1:0] exp_q0[$];
    logic [W+1:0] exp_q1[$];

    int    hold_of [NDUT] = '{3, 1};
    int    m_streak[NDUT];
    int    m_last  [NDUT];
    bit    m_ok    [NDUT];
    bit    m_exp   [NDUT];
    int    m_cls   [NDUT];
    int    m_conf  [NDUT];
    prob_t f [N];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < NDUT; u++) begin
            m_streak[u] = 0; m_last[u] = 0; m_ok[u] = 0;
            m_cls[u] = 0; m_conf[u] = 0; m_exp[u] = 0;
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic model_clear();
        for (int u = 0; u < NDUT; u++) begin
            m_streak[u] = 0; m_ok[u] = 0;
        end
    endtask

    // Winner = lowest index holding the largest value; streak counts consecutive
    // qualifying frames with that same winner.
    task automatic model_frame(input prob_t p [N], input prob_t thr, input bit clr);
        int win = 0;
        bit ok;
        for (int i = 1; i < N; i++) if (p[i] > p[win]) win = i;
        ok = (p[win] >= thr);
        for (int u = 0; u < NDUT; u++) begin
            m_exp[u] = 0;
            if (clr) begin
                m_streak[u] = 0;
                m_ok[u] = 0;
                m_last[u] = win;
            end else begin
                bit cont = ok && m_ok[u] && (win == m_last[u]);
                int ns = !ok ? 0 : (cont ? ((m_streak[u] + 1 > hold_of[u]) ? hold_of[u] : m_streak[u] + 1) : 1);
                m_exp[u] = (ns == hold_of[u]) && !(cont && m_streak[u] == hold_of[u]);
                m_streak[u] = ns;
                m_ok[u] = ok;
                m_last[u] = win;
                if (m_exp[u]) begin
                    m_cls[u] = win;
                    m_conf[u] = int'(p[win]);
                    if (u == 0) exp_q0.push_back({2'(win), p[win]});
                    else        exp_q1.push_back({2'(win), p[win]});
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int u = 0; u < NDUT; u++) begin
            check_eq($sformatf("%s_h%0d_ready", tag, hold_of[u]), rdy[u], 1);
            check_eq($sformatf("%s_h%0d_busy", tag, hold_of[u]), bsy[u], 0);
            check_eq($sformatf("%s_h%0d_det_valid", tag, hold_of[u]), dv[u], 0);
            check_eq($sformatf("%s_h%0d_det_class", tag, hold_of[u]), dcls[u], 0);
            check_eq($sformatf("%s_h%0d_det_conf", tag, hold_of[u]), dconf[u], 0);
            check_eq($sformatf("%s_h%0d_streak", tag, hold_of[u]), stk[u], 0);
            check_eq($sformatf("%s_h%0d_state", tag, hold_of[u]), st[u], IDLE);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_frame(input prob_t a, input prob_t b, input prob_t c, input prob_t d);
        f[0] = a; f[1] = b; f[2] = c; f[3] = d;
    endtask

    task automatic rand_frame(input int cls);
        for (int i = 0; i < N; i++) f[i] = prob_t'($urandom_range(0, 16'h3000));
        f[cls] = prob_t'($urandom_range(16'h3800, 16'hFFFF));
        if ($urandom_range(0, 7) == 0) f[$urandom_range(0, N-1)] = f[cls];
    endtask

    // Called at a negedge; sends f, optionally clears in DECIDE, pokes prob_valid
    // during SCAN, or drops reset mid-scan.
    task automatic send_frame(input prob_t thr, input bit clr, input bit poke, input bit rst_mid);
        int waited = 0;
        bit early = 0;
        prob_t sent [N];
        logic [W+1:0] e;
        while (!(rdy[0] && rdy[1]) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!(rdy[0] && rdy[1])) begin
            check_eq("ready_timeout", 0, 1);
            return;
        end
        sent = f;
        for (int i = 0; i < N; i++) probs[i] = f[i];
        threshold = thr;
        prob_valid = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= N + 2; k++) begin
            @(negedge clk);
            if (k == 1) begin
                prob_valid = 1'b0;
                threshold = prob_t'($urandom);
                for (int i = 0; i < N; i++) probs[i] = prob_t'($urandom);
                check_eq("scan_busy", bsy[0], 1);
                check_eq("scan_state", st[1], SCAN);
            end
            if (poke && k == 2) prob_valid = 1'b1;
            if (poke && k == 3) begin
                check_eq("poke_ready", rdy[0], 0);
                check_eq("poke_state", st[0], SCAN);
                prob_valid = 1'b0;
            end
            if (rst_mid && k == 2) begin
                rst_n = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check_reset_outputs("mid_rst");
                rst_n = 1'b1;
                model_reset();
                check_eq("mid_rst_no_early_det", early, 0);
                return;
            end
            if (k <= N + 1 && (dv[0] || dv[1])) early = 1;
            if (k == N + 1) begin
                check_eq("decide_state", st[0], DECIDE);
                if (clr) clear = 1'b1;
            end
            if (k == N + 2) begin
                clear = 1'b0;
                model_frame(sent, thr, clr);
                for (int u = 0; u < NDUT; u++) begin
                    check_eq($sformatf("h%0d_det_valid", hold_of[u]), dv[u], m_exp[u]);
                    if (dv[u]) begin
                        if (u == 0 && exp_q0.size() > 0) begin
                            e = exp_q0.pop_front();
                            check_eq("h3_sb_pulse", {dcls[u], dconf[u]}, e);
                        end else if (u == 1 && exp_q1.size() > 0) begin
                            e = exp_q1.pop_front();
                            check_eq("h1_sb_pulse", {dcls[u], dconf[u]}, e);
                        end
                    end
                    check_eq($sformatf("h%0d_det_class", hold_of[u]), dcls[u], m_cls[u]);
                    check_eq($sformatf("h%0d_det_conf", hold_of[u]), dconf[u], m_conf[u]);
                    check_eq($sformatf("h%0d_streak", hold_of[u]), stk[u], m_streak[u]);
                    check_eq($sformatf("h%0d_ready_back", hold_of[u]), rdy[u], 1);
                end
            end
        end
        check_eq("no_early_det", early, 0);
    endtask

    task automatic send_class(input int cls, input bit clr);
        set_frame(16'h0800, 16'h0800, 16'h0800, 16'h0800);
        f[cls] = 16'h8000;
        send_frame(16'h4000, clr, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        for (int i = 0; i < N; i++) probs[i] = 16'hFFFF;
        rst_n = 1'b0;
        prob_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check_reset_outputs("reset");
        end
        prob_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("post_reset_state", st[0], IDLE);

        // Stable winner, then a held fourth frame.
        set_frame(16'h1000, 16'h9000, 16'h2000, 16'h1000);
        repeat (4) send_frame(16'h4000, 1'b0, 1'b0, 1'b0);

        // Just below threshold, then exactly at threshold.
        set_frame(16'h3FFF, 16'h1000, 16'h0000, 16'h0000);
        repeat (5) send_frame(16'h4000, 1'b0, 1'b0, 1'b0);
        set_frame(16'h0000, 16'h0100, 16'h4000, 16'h0100);
        repeat (3) send_frame(16'h4000, 1'b0, 1'b0, 1'b0);

        // Tie resolves to index 0.
        set_frame(16'h5000, 16'h2000, 16'h5000, 16'h1000);
        repeat (3) send_frame(16'h4000, 1'b0, 1'b0, 1'b0);

        // Streak break sequence.
        send_class(2, 0); send_class(2, 0); send_class(0, 0);
        send_class(2, 0); send_class(2, 0); send_class(2, 0);

        // Clear collides with DECIDE, then streak rebuilds.
        send_class(3, 0); send_class(3, 0); send_class(3, 1);
        send_class(3, 0); send_class(3, 0); send_class(3, 0);

        // prob_valid during SCAN is ignored.
        set_frame(16'h0100, 16'hA000, 16'h0200, 16'h0300);
        repeat (3) send_frame(16'h4000, 1'b0, 1'b1, 1'b0);

        // Reset during the scan of a third agreeing frame.
        send_class(1, 0); send_class(1, 0);
        send_frame(16'h4000, 1'b0, 1'b0, 1'b1);
        send_class(1, 0); send_class(1, 0); send_class(1, 0);

        // Clear while idle flushes history.
        send_class(0, 0); send_class(0, 0);
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        model_clear();
        check_eq("idle_clear_streak", stk[0], 0);
        send_class(0, 0); send_class(0, 0); send_class(0, 0);

        // Randomized frames, thresholds, clears and pokes.
        for (int n = 0; n < 80; n++) begin
            rand_frame($urandom_range(0, 3) == 0 ? $urandom_range(0, N-1) : 1);
            send_frame(($urandom_range(0, 3) == 0) ? prob_t'($urandom_range(16'h3000, 16'hC000)) : 16'h4000,
                       $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0, 1'b0);
        end

        repeat (4) @(negedge clk);
        check_eq("h3_sb_drained", exp_q0.size(), 0);
        check_eq("h1_sb_drained", exp_q1.size(), 0);

        // ---------------- final report ----------------
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
